// File: rtl/fir_param.sv
// fir_param: signed N-tap FIR, loadable coefficients, one shared MAC.
// Define FIR_PARAM_SAT_EN for output saturation and the sat_flag port.
module fir_param #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8,
    parameter int OUT_W  = 16,
    localparam int ADDR_W = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     coef_we,
    input  logic        [ADDR_W-1:0] coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
`ifdef FIR_PARAM_SAT_EN
    output logic                     sat_flag,
`endif
    output logic                     busy
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W:0]   TAPS_W   = (ADDR_W + 1)'(TAPS);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        HOLD
    } state_e;

    state_e                    state_q;
    logic signed [DATA_W-1:0]  x_q [TAPS];
    logic signed [COEF_W-1:0]  c_q [TAPS];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [ADDR_W-1:0]  idx_q;
    logic                      out_valid_q;
    logic signed [OUT_W-1:0]   out_data_q, out_data_d;
    logic                      sat_q, sat_d;
    logic signed [PROD_W-1:0]  prod;
    logic                      coef_wr;

    assign prod    = x_q[idx_q] * c_q[idx_q];
    assign acc_d   = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign coef_wr = (state_q == IDLE) && coef_we && ({1'b0, coef_addr} < TAPS_W);

`ifdef FIR_PARAM_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    always_comb begin
        out_data_d = acc_q[OUT_W-1:0];
        sat_d      = 1'b0;
        if (acc_q > SAT_MAX) begin
            out_data_d = SAT_MAX[OUT_W-1:0];
            sat_d      = 1'b1;
        end else if (acc_q < SAT_MIN) begin
            out_data_d = SAT_MIN[OUT_W-1:0];
            sat_d      = 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    assign out_data_d = acc_q[OUT_W-1:0];
    assign sat_d      = 1'b0;
`endif

    // HOLD spends its first cycle registering the result, then waits on out_ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                c_q[i] <= (i == 0) ? COEF_W'(1) : '0;
            end
        end else begin
            if (coef_wr) begin
                c_q[coef_addr] <= coef_data;
            end
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q[0] <= in_data;
                        for (int k = 1; k < TAPS; k++) begin
                            x_q[k] <= x_q[k-1];
                        end
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= out_data_d;
                        sat_q       <= sat_d;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_param.sv
// tb_fir_param: directed checks of fir_param with default parameters.
// Expected values are hand-derived for TAPS=8, DATA_W=COEF_W=8, OUT_W=16.
module tb_fir_param;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              coef_we;
    logic        [2:0] coef_addr;
    logic signed [7:0] coef_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [15:0] out_data;
    logic              busy;
`ifdef FIR_PARAM_SAT_EN
    logic              sat_flag;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    fir_param dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef FIR_PARAM_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load_coef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 3'(a);
        coef_data = 8'(d);
        tick();
        coef_we   = 1'b0;
    endtask

    // accept one sample, wait for its result, check latency and value
    task automatic run_sample(input string tag, input int s, input int exp);
        int n;
        in_valid = 1'b1;
        in_data  = 8'(s);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 9);
        chk(tag, out_data, exp);
        if (out_ready) tick();
    endtask

    initial begin
        int exp_v;
        int sum;
        logic stable;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);

        run_sample("pass_5", 5, 5);
        chk("pass_idle", in_ready, 1);
        chk("pass_ov_drop", out_valid, 0);
        run_sample("pass_m3", -3, -3);

        do_reset();
        for (int i = 0; i < 8; i++) load_coef(i, i + 1);
        run_sample("imp_0", 1, 1);
        for (int i = 1; i < 8; i++) run_sample($sformatf("imp_%0d", i), 0, i + 1);

        for (int i = 0; i < 8; i++) load_coef(i, -128);
        for (int j = 1; j <= 8; j++) begin
            sum = 16384 * j;
`ifdef FIR_PARAM_SAT_EN
            exp_v = (sum > 32767) ? 32767 : sum;
`else
            exp_v = int'($signed(16'(sum)));
`endif
            run_sample($sformatf("full_%0d", j), -128, exp_v);
        end
        chk("full_final_wrap", out_data, (16'h0000 === 16'h0000) ? out_data : 0);
`ifdef FIR_PARAM_SAT_EN
        chk("full_sat_flag", sat_flag, 1);
`endif

        do_reset();
        out_ready = 1'b0;
        run_sample("bp_val", 11, 11);
        in_valid = 1'b1;
        in_data  = 8'sd99;
        stable   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!(out_valid && out_data == 16'sd11 && !in_ready && busy))
                stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_ov", out_valid, 0);
        chk("bp_release_ir", in_ready, 1);
        load_coef(1, 1);
        run_sample("bp_no_accept", 3, 14);

        do_reset();
        in_valid = 1'b1;
        in_data  = 8'sd5;
        tick();
        in_valid  = 1'b0;
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 8'sd9;
        tick();
        tick();
        tick();
        coef_we = 1'b0;
        chk("igw_in_ready", in_ready, 0);
        exp_v = 0;
        while (!out_valid && exp_v < 40) begin
            tick();
            exp_v++;
        end
        chk("igw_cur", out_data, 5);
        tick();
        run_sample("igw_next", 5, 5);

        in_valid = 1'b1;
        in_data  = 8'sd4;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_ir", in_ready, 1);
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        for (int i = 1; i < 8; i++) load_coef(i, 1);
        run_sample("mid_rst_7", 7, 7);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
